// File: rtl/wave_sweep_scheduler.sv
// Sequences one combinational wave_unit over an N_CELLS (u,du) array in external RAM,
// running n_steps Jacobi-style sweeps with zero Dirichlet boundaries at both ends.
module wave_sweep_scheduler #(
    parameter int unsigned N_CELLS = 100,
    parameter int unsigned AW      = 7,
    parameter int unsigned DW      = 32,
    parameter int unsigned CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] n_steps,
    input  logic          halt,
    output logic          busy,
    output logic          sweep_done,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_u,
    input  logic [DW-1:0] rd_du,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_u,
    output logic [DW-1:0] wr_du,
    output logic [DW-1:0] wu_u,
    output logic [DW-1:0] wu_du,
    output logic [DW-1:0] wu_uL,
    output logic [DW-1:0] wu_uR,
    input  logic [DW-1:0] wu_u_new,
    input  logic [DW-1:0] wu_du_new
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH1,
        S_CALC,
        S_FIN
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] idx;
    logic [CW-1:0] n_lat;
    logic [CW-1:0] sweep_cnt;
    logic          halt_seen;
    logic          sweep_done_q;
    logic [DW-1:0] prev_u;
    logic [DW-1:0] cur_u;
    logic [DW-1:0] cur_du;
    logic          last_cell;
    logic          run_end;
    logic          fetch_ahead;

    assign last_cell   = (idx == AW'(N_CELLS - 1));
    assign fetch_ahead = ((32'(idx) + 32'd2) < N_CELLS);
    // Decided during the last CALC cycle, so a halt arriving in that very cycle still counts.
    assign run_end     = ((sweep_cnt + 1'b1) == n_lat) || halt_seen || halt;

    assign wr_u       = wu_u_new;
    assign wr_du      = wu_du_new;
    assign sweep_done = sweep_done_q;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wu_u      = '0;
        wu_du     = '0;
        wu_uL     = '0;
        wu_uR     = '0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (n_steps == '0) ? S_FIN : S_FETCH0;
            end
            S_FETCH0: begin
                busy      = 1'b1;
                rd_en     = 1'b1;
                state_nxt = S_FETCH1;
            end
            S_FETCH1: begin
                busy      = 1'b1;
                rd_en     = 1'b1;
                rd_addr   = AW'(1);
                state_nxt = S_CALC;
            end
            S_CALC: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = idx;
                wu_uL   = prev_u;
                wu_u    = cur_u;
                wu_du   = cur_du;
                wu_uR   = last_cell ? '0 : rd_u;
                if (fetch_ahead) begin
                    rd_en   = 1'b1;
                    rd_addr = AW'(32'(idx) + 32'd2);
                end
                if (last_cell) state_nxt = run_end ? S_FIN : S_FETCH0;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            n_lat        <= '0;
            sweep_cnt    <= '0;
            halt_seen    <= 1'b0;
            sweep_done_q <= 1'b0;
            prev_u       <= '0;
            cur_u        <= '0;
            cur_du       <= '0;
        end else begin
            state        <= state_nxt;
            sweep_done_q <= 1'b0;
            if (state != S_IDLE && halt) halt_seen <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_lat     <= n_steps;
                        sweep_cnt <= '0;
                        halt_seen <= 1'b0;
                    end
                end
                S_FETCH1: begin
                    cur_u  <= rd_u;
                    cur_du <= rd_du;
                    prev_u <= '0;
                    idx    <= '0;
                end
                S_CALC: begin
                    // Window slides on old values; write-back never feeds the next cell.
                    prev_u <= cur_u;
                    cur_u  <= rd_u;
                    cur_du <= rd_du;
                    if (last_cell) begin
                        idx          <= '0;
                        sweep_done_q <= 1'b1;
                        sweep_cnt    <= sweep_cnt + 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_sweep_scheduler.sv
// Directed bench: 4-cell RAM model plus a simple integer wave_unit, hand-computed sweep tables.
module tb_wave_sweep_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] n_steps;
    logic          halt;
    logic          busy, sweep_done, done;
    logic          rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_u, rd_du, wr_u, wr_du;
    logic [DW-1:0] wu_u, wu_du, wu_uL, wu_uR, wu_u_new, wu_du_new;

    wave_sweep_scheduler #(.N_CELLS(N), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_steps(n_steps), .halt(halt),
        .busy(busy), .sweep_done(sweep_done), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_u(rd_u), .rd_du(rd_du),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_u(wr_u), .wr_du(wr_du),
        .wu_u(wu_u), .wu_du(wu_du), .wu_uL(wu_uL), .wu_uR(wu_uR),
        .wu_u_new(wu_u_new), .wu_du_new(wu_du_new)
    );

    // wave_unit stand-in: du' = du + uL + uR - 2u ; u' = u + du'
    assign wu_du_new = wu_du + wu_uL + wu_uR - (wu_u << 1);
    assign wu_u_new  = wu_u + wu_du_new;

    logic [DW-1:0] mem_u [N];
    logic [DW-1:0] mem_du[N];
    logic [DW-1:0] init_u[N];
    logic          load_req;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) begin
                mem_u[i]  <= init_u[i];
                mem_du[i] <= '0;
            end
        end else if (wr_en) begin
            mem_u[wr_addr]  <= wr_u;
            mem_du[wr_addr] <= wr_du;
        end
        if (rd_en) begin
            rd_u  <= mem_u[rd_addr];
            rd_du <= mem_du[rd_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0, done_cnt = 0, sd_cnt = 0, rd_cnt = 0, wr_cnt = 0, busy_cnt = 0;
    int done_cyc = 0, sd_last = 0, sd_prev = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (sweep_done) begin
            sd_cnt  = sd_cnt + 1;
            sd_prev = sd_last;
            sd_last = cyc;
        end
        if (rd_en) rd_cnt = rd_cnt + 1;
        if (wr_en) wr_cnt = wr_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int c0;

    // Leaves the bench in cycle 1 after the accepted start (c0 = cycle 0).
    task automatic kick(input int n);
        tick();
        start   = 1'b1;
        n_steps = CW'(n);
        c0      = cyc;
        tick();
        start   = 1'b0;
    endtask

    task automatic load_ram();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < 200 && done_cnt == d0; k++) tick();
        check("done_seen", 32'(done_cnt != d0), 32'd1);
    endtask

    int s1_u[N]  = '{256, -256, 256, 0};
    int s1_du[N] = '{256, -512, 256, 0};
    int s3_u[N]  = '{0, -256, 256, -256};
    int s3_du[N] = '{256, -512, 512, -512};

    int d0, s0, r0, w0, b0;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        n_steps  = '0;
        halt     = 1'b0;
        load_req = 1'b0;
        init_u   = '{32'd0, 32'd256, 32'd0, 32'd0};
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sweep_done", 32'(sweep_done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_addrs", 32'({rd_addr, wr_addr}), 32'd0);
        rst_n = 1'b1;
        load_ram();

        // single sweep, cycle by cycle
        kick(1);
        check("a_c1_rd", 32'({busy, rd_en, rd_addr}), 32'b1100);
        tick();
        check("a_c2_rd", 32'({rd_en, rd_addr}), 32'b101);
        tick();
        check("a_c3", 32'({wr_en, wr_addr, rd_en, rd_addr}), 32'b100110);
        tick();
        check("a_c4_addr", 32'(wr_addr), 32'd1);
        check("a_c4_uL", wu_uL, 32'd0);
        check("a_c4_u", wu_u, 32'd256);
        check("a_c4_uR", wu_uR, 32'd0);
        check("a_c4_wr_u", wr_u, 32'hFFFF_FF00);
        check("a_c4_wr_du", wr_du, 32'hFFFF_FE00);
        tick();
        check("a_c5_addr", 32'(wr_addr), 32'd2);
        check("a_c5_uL", wu_uL, 32'd256);
        check("a_c5_u", wu_u, 32'd0);
        check("a_c5_uR", wu_uR, 32'd0);
        tick();
        check("a_c6", 32'({wr_en, wr_addr, rd_en}), 32'b1110);
        tick();
        check("a_c7_end", 32'({done, sweep_done, busy}), 32'b110);
        tick();
        check("a_c8_idle", 32'({done, sweep_done, wr_en}), 32'b000);
        for (int i = 0; i < N; i++) begin
            check($sformatf("a_u%0d", i), mem_u[i], s1_u[i]);
            check($sformatf("a_du%0d", i), mem_du[i], s1_du[i]);
        end

        // zero-step run
        r0 = rd_cnt; w0 = wr_cnt; b0 = busy_cnt; d0 = done_cnt;
        kick(0);
        check("z_done", 32'({done, busy}), 32'b10);
        tick(); tick(); tick();
        check("z_traffic", 32'((rd_cnt - r0) + (wr_cnt - w0) + (busy_cnt - b0)), 32'd0);
        check("z_done_cnt", 32'(done_cnt - d0), 32'd1);

        // three sweeps with a start retry mid-run
        load_ram();
        d0 = done_cnt; s0 = sd_cnt;
        kick(3);
        while (cyc - c0 < 5) tick();
        start = 1'b1; n_steps = CW'(7);
        tick();
        start = 1'b0;
        wait_done(d0);
        check("m_done_lat", 32'(done_cyc - c0), 32'd19);
        check("m_sweeps", 32'(sd_cnt - s0), 32'd3);
        check("m_sd_gap", 32'(sd_last - sd_prev), 32'd6);
        for (int k = 0; k < 10; k++) tick();
        check("m_no_restart", 32'({done_cnt - d0, 31'(busy)}), 32'({32'd1, 31'd0}));
        for (int i = 0; i < N; i++) begin
            check($sformatf("m_u%0d", i), mem_u[i], s3_u[i]);
            check($sformatf("m_du%0d", i), mem_du[i], s3_du[i]);
        end

        // halt during sweep 1 of 5
        load_ram();
        d0 = done_cnt; s0 = sd_cnt;
        kick(5);
        tick(); tick(); tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_done(d0);
        check("h_done_lat", 32'(done_cyc - c0), 32'd7);
        check("h_sweeps", 32'(sd_cnt - s0), 32'd1);
        check("h_u1", mem_u[1], s1_u[1]);
        check("h_u2", mem_u[2], s1_u[2]);

        // asynchronous reset in CALC cell 2
        load_ram();
        kick(1);
        tick(); tick(); tick(); tick();
        check("r_pre_addr", 32'({wr_en, wr_addr}), 32'b110);
        rst_n = 1'b0;
        #1;
        check("r_outs", 32'({busy, done, sweep_done, rd_en, wr_en, rd_addr, wr_addr}), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("r_u1", mem_u[1], s1_u[1]);
        check("r_u2", mem_u[2], 32'd0);
        check("r_u3", mem_u[3], 32'd0);
        check("r_du2", mem_du[2], 32'd0);
        check("r_idle", 32'({busy, wr_en}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
